// File: rtl/quad_encoder_counter_if.sv
// Encoder front-end bus: raw A/B lines and clear in, windowed count and flags out.
interface quad_encoder_counter_if;
   logic        enc_a;
   logic        enc_b;
   logic        clr;
   logic [31:0] code;
   logic        valid;
   logic        err;

   modport master (
      output enc_a, enc_b, clr,
      input  code, valid, err
   );

   modport slave (
      input  enc_a, enc_b, clr,
      output code, valid, err
   );
endinterface

// File: rtl/quad_encoder_counter.sv
// Quadrature encoder front end: synchronizes A/B, decodes at 4x resolution and reports the
// saturated signed count of each PERIOD-cycle window with a one-cycle valid strobe.
module quad_encoder_counter #(
   parameter int unsigned PERIOD = 50000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   quad_encoder_counter_if.slave bus
);

   localparam int unsigned     CntW    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(PERIOD - 1);
   localparam logic [31:0]     AccMax  = 32'h7FFF_FFFF;
   localparam logic [31:0]     AccMin  = 32'h8000_0000;

   logic [1:0]      s1_q, s2_q, prev_q;
   logic [1:0]      prime_q, prime_d;
   logic [31:0]     acc_q, acc_d, acc_sum;
   logic [31:0]     code_q, code_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            valid_q, valid_d;
   logic            err_q, err_d;
   logic            priming, step_up, step_dn, illegal;
   logic [1:0]      delta;

   // Position of {A,B} along the forward cycle 00 -> 10 -> 11 -> 01.
   function automatic logic [1:0] gray_pos(input logic [1:0] ab);
      return {ab[0], ab[1] ^ ab[0]};
   endfunction

   // Step decode of prev -> s2 plus the saturated accumulator sum for this cycle.
   always_comb begin
      priming = (prime_q != 2'd3);
      delta   = gray_pos(s2_q) - gray_pos(prev_q);
      step_up = !priming && (delta == 2'b01);
      step_dn = !priming && (delta == 2'b11);
      illegal = !priming && (delta == 2'b10);
      acc_sum = acc_q;
      if (step_up && (acc_q != AccMax)) begin
         acc_sum = acc_q + 32'd1;
      end else if (step_dn && (acc_q != AccMin)) begin
         acc_sum = acc_q - 32'd1;
      end
   end

   // Window, accumulator and flag next-state; clr overrides the window close.
   always_comb begin
      prime_d = priming ? prime_q + 2'd1 : prime_q;
      acc_d   = acc_sum;
      cnt_d   = cnt_q + 1'b1;
      code_d  = code_q;
      valid_d = 1'b0;
      err_d   = err_q | illegal;
      if (bus.clr) begin
         acc_d  = '0;
         cnt_d  = '0;
         code_d = '0;
         err_d  = 1'b0;
      end else if (cnt_q == CntLast) begin
         // The closing cycle's own step belongs to the window being reported.
         code_d  = acc_sum;
         acc_d   = '0;
         cnt_d   = '0;
         valid_d = 1'b1;
      end
   end

   // State registers; prev always trails s2 so priming and clr need no special case.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q    <= 2'b00;
         s2_q    <= 2'b00;
         prev_q  <= 2'b00;
         prime_q <= 2'd0;
         acc_q   <= '0;
         cnt_q   <= '0;
         code_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         s1_q    <= {bus.enc_a, bus.enc_b};
         s2_q    <= s1_q;
         prev_q  <= s2_q;
         prime_q <= prime_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign bus.code  = code_q;
   assign bus.valid = valid_q;
   assign bus.err   = err_q;

endmodule
